mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL be the memory word-index width (256 words).
REQ-002 Parameter MAX_WAIT, default 4, SHALL be the consecutive denied cycles before the instruction port is forced to win.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  instruction-fetch read request.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  fetch data valid.
REQ-009 if_rdata  output  32  fetch data.
REQ-010 d_req  input  1  load/store request.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  32  data byte address.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_wstrb  input  4  store byte enables.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  load data valid, or store acknowledge.
REQ-017 d_rdata  output  32  load data; 0 on store acknowledge.
REQ-018 mem_en, mem_we  output  1 each  memory access strobe and write select.
REQ-019 mem_addr  output  ADDR_W  word index.
REQ-020 mem_wdata  output  32  write data.
REQ-021 mem_wmask  output  4  write byte mask.
REQ-022 mem_rdata  input  32  read data, valid one cycle after a read strobe.

Function
REQ-023 Grants SHALL be combinational from req and arbiter state; at most one of if_gnt/d_gnt SHALL be high per cycle.
REQ-024 On a grant, mem_en SHALL be 1 in the same cycle; mem_addr = addr[ADDR_W+1:2]; upper address bits are ignored, giving wrap-around.
REQ-025 Response SHALL occur exactly 1 cycle after the grant: if_rvalid or d_rvalid high for 1 cycle, with rdata = mem_rdata.
REQ-026 A new grant SHALL be allowed in a response cycle, giving 1 access per cycle throughput.
REQ-027 A registered owner field {NONE, IF, D} SHALL record which port receives the next response; it returns to NONE when there is no grant.
REQ-028 Default priority: data SHALL win when both ports request.
REQ-029 A counter SHALL count consecutive cycles with if_req=1 and if_gnt=0.
  - At MAX_WAIT, the fetch port SHALL win the next contention.
  - The counter SHALL clear on if_gnt or when if_req=0.
REQ-030 Requesters hold req, addr and data stable until gnt; dropping req before gnt SHALL abandon the request without a memory access.
REQ-031 With no grant, mem_en, mem_we and mem_wmask SHALL be 0.
REQ-032 A store SHALL drive mem_we=1 and mem_wmask=d_wstrb; d_wstrb=0 SHALL still strobe and still be acknowledged.

Reset
REQ-033 While reset=0:
  - owner=NONE and the wait counter=0;
  - all gnt, rvalid, mem_en and mem_we outputs SHALL be 0, and rdata outputs 0.
REQ-034 Reset mid-transaction SHALL discard the outstanding response; no rvalid SHALL follow the release of reset.

Configuration
REQ-035 With MEM_ARB_RR_EN defined:
  - contention SHALL alternate winners via a 1-bit last-winner register (reset value: IF last, so data wins first);
  - the wait counter is omitted.
  Without MEM_ARB_RR_EN, REQ-028 and REQ-029 apply.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the owner enum, the ADDR_W and MAX_WAIT defaults, and the response-latency constant (1).
REQ-037 Sub-module arb_pick SHALL be the combinational two-way winner selection; state stays in mem_arbiter.

Verification
REQ-038 Fetch-only read: if_req=1, if_addr=0x10 -> if_gnt same cycle, mem_addr=4; next cycle if_rvalid=1, if_rdata=mem_rdata.
REQ-039 Contention: both ports request for 6 cycles, MAX_WAIT=4 -> d_gnt in cycles 1-4, if_gnt in cycle 5, d_gnt in cycle 6.
REQ-040 Store: d_we=1, d_addr=0x3FC, d_wstrb=0x3, d_wdata=0xA5A5A5A5 -> mem_addr=0xFF, mem_wmask=0x3; next cycle d_rvalid=1, d_rdata=0.
REQ-041 Wrap and throughput: if_addr=0x400 -> mem_addr=0; back-to-back fetches -> if_rvalid high every cycle.
REQ-042 Reset asserted in the cycle after a grant -> no rvalid, owner=NONE after release.
REQ-043 With MEM_ARB_RR_EN defined, continuous contention -> grants D, IF, D, IF.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Owner encoding, geometry defaults and response latency.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int ADDR_W_DEF   = 8;
  localparam int MAX_WAIT_DEF = 4;
  localparam int RESP_LAT     = 1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way winner selection for mem_arbiter.
// if_first gives the fetch port priority under contention.
module arb_pick (
  input  logic if_req,
  input  logic d_req,
  input  logic if_first,
  output logic if_win,
  output logic d_win
);

  assign if_win = if_req & (~d_req | if_first);
  assign d_win  = d_req & ~if_win;

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data single-port memory arbiter, one access per cycle.
// MEM_ARB_RR_EN selects round-robin instead of data-first + starvation timer.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata
);

  owner_t owner;
  logic   store_q;
  logic   if_first;
  logic   if_win;
  logic   d_win;

`ifdef MEM_ARB_RR_EN
  logic last_d;

  assign if_first = last_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_d <= 1'b0;
    end else if (if_gnt) begin
      last_d <= 1'b0;
    end else if (d_gnt) begin
      last_d <= 1'b1;
    end
  end
`else
  localparam int WAIT_W = $clog2(MAX_WAIT + 2);

  logic [WAIT_W-1:0] wait_cnt;

  assign if_first = (wait_cnt >= WAIT_W'(MAX_WAIT));

  // Never exceeds MAX_WAIT: at the limit the fetch port wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (if_req && !if_gnt) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end
`endif

  arb_pick u_pick (
    .if_req   (if_req & reset),
    .d_req    (d_req & reset),
    .if_first (if_first),
    .if_win   (if_win),
    .d_win    (d_win)
  );

  assign if_gnt    = if_win;
  assign d_gnt     = d_win;
  assign mem_en    = if_win | d_win;
  assign mem_we    = d_win & d_we;
  assign mem_wmask = mem_we ? d_wstrb : 4'h0;
  assign mem_wdata = mem_we ? d_wdata : 32'h0;

  always_comb begin
    mem_addr = '0;
    unique case (1'b1)
      d_win:   mem_addr = d_addr[ADDR_W+1:2];
      if_win:  mem_addr = if_addr[ADDR_W+1:2];
      default: mem_addr = '0;
    endcase
  end

  logic unused_addr;
  assign unused_addr = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                         d_addr[31:ADDR_W+2], d_addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner   <= OWN_NONE;
      store_q <= 1'b0;
    end else begin
      store_q <= d_win & d_we;
      unique case (1'b1)
        if_win:  owner <= OWN_IF;
        d_win:   owner <= OWN_D;
        default: owner <= OWN_NONE;
      endcase
    end
  end

  assign if_rvalid = (owner == OWN_IF);
  assign d_rvalid  = (owner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
  assign d_rdata   = (d_rvalid && !store_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random and directed traffic
// against a transaction-level model with its own memory image.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic [3:0]    d_wstrb;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_rdata;

  mem_arbiter #(.ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          ig;
    bit          dg;
    bit          we;
    logic [7:0]  addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    int          cyc;
  } cyc_t;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  cyc_t q_cyc[$];
  rsp_t q_rsp[$];
  int   errors = 0;
  int   checks = 0;

  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];

  int          wait_n = 0;
  bit          last_d = 1'b0;
  int          cyc_n  = 0;

  bit          if_act = 1'b0;
  logic [31:0] if_a   = '0;
  bit          d_act  = 1'b0;
  bit          d_w    = 1'b0;
  logic [31:0] d_a    = '0;
  logic [31:0] d_wd   = '0;
  logic [3:0]  d_st   = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Environment memory: answers strobes one cycle later.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b])
            env_mem[mem_addr][b*8 +: 8] = mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= env_mem[mem_addr];
      end
    end
  end

  // Monitor: compares every cycle against the queued expectations.
  initial begin
    cyc_t r;
    bit   has;
    rsp_t e;
    forever begin
      @(negedge clk);
      if (q_cyc.size() > 0) begin
        r = q_cyc.pop_front();
        chk("if_gnt", 32'(if_gnt), 32'(r.ig));
        chk("d_gnt", 32'(d_gnt), 32'(r.dg));
        chk("mem_en", 32'(mem_en), 32'(r.ig | r.dg));
        chk("mem_we", 32'(mem_we), 32'(r.we));
        chk("mem_wmask", 32'(mem_wmask), 32'(r.wmask));
        if (r.ig | r.dg) chk("mem_addr", 32'(mem_addr), 32'(r.addr));
        if (r.we) chk("mem_wdata", mem_wdata, r.wdata);
        has = (q_rsp.size() > 0) && (q_rsp[0].cyc == r.cyc);
        if (has) e = q_rsp.pop_front();
        chk("if_rvalid", 32'(if_rvalid), 32'(has && !e.is_d));
        chk("d_rvalid", 32'(d_rvalid), 32'(has && e.is_d));
        if (has && !e.is_d) chk("if_rdata", if_rdata, e.data);
        if (has && e.is_d) chk("d_rdata", d_rdata, e.data);
        if (r.rst) begin
          chk("rst_if_rdata", if_rdata, 32'h0);
          chk("rst_d_rdata", d_rdata, 32'h0);
        end
      end
    end
  end

  // One cycle of stimulus plus the model's expectation for it.
  task automatic step(input bit hold_rst);
    cyc_t c;
    bit   ig, dg, pri;
    int   idx;
    reset   = ~hold_rst;
    if_req  = if_act;
    if_addr = if_a;
    d_req   = d_act;
    d_we    = d_w;
    d_addr  = d_a;
    d_wdata = d_wd;
    d_wstrb = d_st;
    c = '{rst: hold_rst, ig: 0, dg: 0, we: 0, addr: 0,
          wmask: 0, wdata: 0, cyc: cyc_n};
    if (hold_rst) begin
      wait_n = 0;
      last_d = 1'b0;
      q_rsp.delete();
    end else begin
`ifdef MEM_ARB_RR_EN
      pri = last_d;
`else
      pri = (wait_n >= MW);
`endif
      ig = if_act && (!d_act || pri);
      dg = d_act && !ig;
      c.ig = ig;
      c.dg = dg;
      if (ig) begin
        idx = int'(if_a[9:2]);
        c.addr = if_a[9:2];
        q_rsp.push_back('{is_d: 0, data: ref_mem[idx], cyc: cyc_n + 1});
      end
      if (dg) begin
        idx = int'(d_a[9:2]);
        c.addr = d_a[9:2];
        if (d_w) begin
          c.we = 1;
          c.wmask = d_st;
          c.wdata = d_wd;
          for (int b = 0; b < 4; b++)
            if (d_st[b]) ref_mem[idx][b*8 +: 8] = d_wd[b*8 +: 8];
          q_rsp.push_back('{is_d: 1, data: 32'h0, cyc: cyc_n + 1});
        end else begin
          q_rsp.push_back('{is_d: 1, data: ref_mem[idx], cyc: cyc_n + 1});
        end
      end
      wait_n = (if_act && !ig) ? wait_n + 1 : 0;
      if (dg) last_d = 1'b1;
      else if (ig) last_d = 1'b0;
    end
    q_cyc.push_back(c);
    @(posedge clk);
    #1;
    cyc_n++;
    if (c.ig) if_act = 1'b0;
    if (c.dg) d_act = 1'b0;
  endtask

  task automatic new_if(input logic [31:0] a);
    if_act = 1'b1;
    if_a   = a;
  endtask

  task automatic new_d(input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
    d_act = 1'b1;
    d_w   = w;
    d_a   = a;
    d_wd  = wd;
    d_st  = st;
  endtask

  initial begin
    reset   = 1'b0;
    if_req  = 0;
    if_addr = '0;
    d_req   = 0;
    d_we    = 0;
    d_addr  = '0;
    d_wdata = '0;
    d_wstrb = '0;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    @(posedge clk);
    #1;
    step(1);
    new_if(32'h10);
    new_d(1'b0, 32'h20, 32'h0, 4'h0);
    step(1);
    d_act = 1'b0;
    step(0);
    step(0);
    for (int k = 0; k < 6; k++) begin
      if (!if_act) new_if(32'h40 + 32'(k * 4));
      if (!d_act) new_d(k[0], 32'h80 + 32'(k * 4), $urandom, 4'hF);
      step(0);
    end
    if_act = 1'b0;
    d_act  = 1'b0;
    step(0);
    new_d(1'b1, 32'h3FC, 32'hA5A5A5A5, 4'h3);
    step(0);
    new_d(1'b1, 32'h100, 32'h12345678, 4'h0);
    step(0);
    new_d(1'b0, 32'h3FC, 32'h0, 4'h0);
    step(0);
    for (int k = 0; k < 5; k++) begin
      new_if(32'h400 + 32'(k * 4));
      step(0);
    end
    new_if(32'h24);
    step(0);
    step(1);
    step(1);
    step(0);
    step(0);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 249) == 0) begin
        step(1);
        step(1);
      end else begin
        step(0);
      end
      if (!if_act && $urandom_range(0, 3) != 0) new_if($urandom);
      else if (if_act && $urandom_range(0, 15) == 0) if_act = 1'b0;
      if (!d_act && $urandom_range(0, 2) != 0)
        new_d($urandom_range(0, 1) == 1, $urandom, $urandom,
              4'($urandom));
      else if (d_act && $urandom_range(0, 15) == 0) d_act = 1'b0;
    end
    if_act = 1'b0;
    d_act  = 1'b0;
    step(0);
    step(0);
    step(0);
    @(negedge clk);
    #1;
    chk("rsp_drain", 32'(q_rsp.size()), 32'h0);
    chk("cyc_drain", 32'(q_cyc.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
